// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared sizing constants and FSM state encoding for the score BCD sequencer
package score_pkg;

    // Binary input width, BCD digit count and the largest value the display can show.
    localparam int BIN_W   = 17;
    localparam int N_DIG   = 5;
    localparam int MAX_VAL = 99999;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/score_bcd_sequencer_dabble.sv
// rtl/score_bcd_sequencer_dabble.sv - one combinational double-dabble step (add-3 then shift left)
//
// Ports:
//   digits      - current working BCD digits, most significant digit in the top nibble
//   binary      - remaining binary bits still to be shifted in (MSB first)
//   next_digits - digits after the add-3 correction and a 1-bit left shift
//   next_binary - binary after a 1-bit left shift (a zero enters at the bottom)
module bcd_dabble_step #(
    parameter int N_DIG = score_pkg::N_DIG,
    parameter int BIN_W = score_pkg::BIN_W
) (
    input  logic [4*N_DIG-1:0] digits,
    input  logic [BIN_W-1:0]   binary,
    output logic [4*N_DIG-1:0] next_digits,
    output logic [BIN_W-1:0]   next_binary
);

    logic [4*N_DIG-1:0] adjusted;

    // A digit of 5 or more would exceed 9 after doubling, so pre-correct it by 3
    // so that the carry lands in the next digit after the shift.
    always_comb begin
        adjusted = digits;
        for (int i = 0; i < N_DIG; i++) begin
            if (digits[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift the concatenation as one register so the binary MSB enters digit 0.
    assign {next_digits, next_binary} = {adjusted, binary} << 1;

endmodule

// File: rtl/score_bcd_sequencer.sv
// rtl/score_bcd_sequencer.sv - arbitrates score/best requests and converts them to BCD banks
//
// Ports:
//   clk, resetN          - clock (rising edge) and asynchronous active-low reset
//   req_score, score_val - one-cycle request pulse and binary current score
//   req_best, best_val   - one-cycle request pulse and binary high score
//   busy                 - high whenever the sequencer is not idle
//   done, done_src       - one-cycle completion pulse and its source (0 score, 1 best)
//   score_bcd, best_bcd  - BCD result banks, most significant digit in the top nibble
//   ovf_score, ovf_best  - last converted value of that source exceeded MAX_VAL
module score_bcd_sequencer #(
    parameter int BIN_W   = score_pkg::BIN_W,
    parameter int N_DIG   = score_pkg::N_DIG,
    parameter int MAX_VAL = score_pkg::MAX_VAL
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               req_score,
    input  logic [BIN_W-1:0]   score_val,
    input  logic               req_best,
    input  logic [BIN_W-1:0]   best_val,
    output logic               busy,
    output logic               done,
    output logic               done_src,
    output logic [4*N_DIG-1:0] score_bcd,
    output logic [4*N_DIG-1:0] best_bcd,
    output logic               ovf_score,
    output logic               ovf_best
);

    import score_pkg::*;

    // Wide enough to hold BIN_W itself, so the count never wraps mid-conversion.
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e             state;
    logic               pend_score;
    logic               pend_best;
    logic               rr_ptr;      // 0 = score has priority on a tie, 1 = best
    logic               src;         // source granted for the conversion in flight
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   bin_q;
    logic [4*N_DIG-1:0] bcd_q;
    logic               ovf_q;

    logic               grant_any;
    logic               grant_best;
    logic               grant_score_fire;
    logic               grant_best_fire;
    logic [BIN_W-1:0]   value_sel;
    logic               ovf_next;
    logic               last_shift;
    logic [4*N_DIG-1:0] step_digits;
    logic [BIN_W-1:0]   step_binary;
    logic [4*N_DIG-1:0] nines;
    logic [4*N_DIG-1:0] result;

    // Arbitration: a lone pending source wins outright; on a tie the pointer decides.
    assign grant_any        = (state == ST_IDLE) && (pend_score || pend_best);
    assign grant_best       = pend_best && (!pend_score || rr_ptr);
    assign grant_score_fire = grant_any && !grant_best;
    assign grant_best_fire  = grant_any && grant_best;

    assign value_sel  = src ? best_val : score_val;
    assign ovf_next   = 32'(value_sel) > 32'(MAX_VAL);
    assign last_shift = (state == ST_SHIFT) && (cnt == CNT_W'(BIN_W - 1));
    assign busy       = (state != ST_IDLE);

    for (genvar g = 0; g < N_DIG; g++) begin : g_nines
        assign nines[4*g +: 4] = 4'd9;
    end

    // An out-of-range value saturates the display rather than showing wrapped digits.
    assign result = ovf_q ? nines : step_digits;

    bcd_dabble_step #(
        .N_DIG (N_DIG),
        .BIN_W (BIN_W)
    ) u_step (
        .digits      (bcd_q),
        .binary      (bin_q),
        .next_digits (step_digits),
        .next_binary (step_binary)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            pend_score <= 1'b0;
            pend_best  <= 1'b0;
            rr_ptr     <= 1'b0;
            src        <= 1'b0;
            cnt        <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done       <= 1'b0;
            done_src   <= 1'b0;
            score_bcd  <= '0;
            best_bcd   <= '0;
            ovf_score  <= 1'b0;
            ovf_best   <= 1'b0;
        end else begin
            // A request in the grant cycle re-arms the flag, so it is never dropped.
            pend_score <= (pend_score && !grant_score_fire) || req_score;
            pend_best  <= (pend_best && !grant_best_fire) || req_best;
            done       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state  <= ST_LOAD;
                        src    <= grant_best;
                        rr_ptr <= !grant_best;
                    end
                end
                ST_LOAD: begin
                    bin_q <= value_sel;
                    bcd_q <= '0;
                    ovf_q <= ovf_next;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd_q <= step_digits;
                    bin_q <= step_binary;
                    cnt   <= cnt + 1'b1;
                    if (last_shift) begin
                        // The bank is written here so it already holds the result during DONE.
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        done_src <= src;
                        if (src) begin
                            best_bcd <= result;
                            ovf_best <= ovf_q;
                        end else begin
                            score_bcd <= result;
                            ovf_score <= ovf_q;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_sequencer.sv
// tb/tb_score_bcd_sequencer.sv - directed self-checking bench for score_bcd_sequencer
module tb_score_bcd_sequencer;

    logic        clk;
    logic        resetN;
    logic        req_score;
    logic [16:0] score_val;
    logic        req_best;
    logic [16:0] best_val;
    logic        busy;
    logic        done;
    logic        done_src;
    logic [19:0] score_bcd;
    logic [19:0] best_bcd;
    logic        ovf_score;
    logic        ovf_best;

    int errors = 0;
    int checks = 0;

    score_bcd_sequencer dut (
        .clk       (clk),
        .resetN    (resetN),
        .req_score (req_score),
        .score_val (score_val),
        .req_best  (req_best),
        .best_val  (best_val),
        .busy      (busy),
        .done      (done),
        .done_src  (done_src),
        .score_bcd (score_bcd),
        .best_bcd  (best_bcd),
        .ovf_score (ovf_score),
        .ovf_best  (ovf_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk20(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives the request(s) for one cycle (cycle 0); returns in cycle 1.
    task automatic pulse(input logic s, input logic b, input logic [16:0] sv, input logic [16:0] bv);
        if (s) score_val = sv;
        if (b) best_val = bv;
        req_score = s;
        req_best  = b;
        tick;
        req_score = 1'b0;
        req_best  = 1'b0;
    endtask

    // Advances until done is seen or the budget runs out; n is the number of ticks taken.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        chk1(tag, done, 1'b1);
    endtask

    task automatic count_done(input int cycles, output int cnt, output logic [19:0] last_bcd);
        cnt = 0;
        last_bcd = 20'hfffff;
        for (int i = 0; i < cycles; i++) begin
            tick;
            if (done === 1'b1) begin
                cnt++;
                last_bcd = score_bcd;
            end
        end
    endtask

    task automatic do_reset;
        resetN = 1'b0;
        tick;
        tick;
        resetN = 1'b1;
    endtask

    int          n;
    int          dcnt;
    logic [19:0] cap;

    initial begin
        resetN    = 1'b0;
        req_score = 1'b0;
        req_best  = 1'b0;
        score_val = '0;
        best_val  = '0;
        #2;
        chk1 ("rst busy", busy, 1'b0);
        chk1 ("rst done", done, 1'b0);
        chk1 ("rst done_src", done_src, 1'b0);
        chk20("rst score_bcd", score_bcd, 20'h00000);
        chk20("rst best_bcd", best_bcd, 20'h00000);
        chk1 ("rst ovf_score", ovf_score, 1'b0);
        chk1 ("rst ovf_best", ovf_best, 1'b0);
        tick;
        resetN = 1'b1;
        tick;

        // 12345: latency, result, and insensitivity to input changes after LOAD.
        pulse(1'b1, 1'b0, 17'd12345, 17'd0);
        chk1("c1 busy idle", busy, 1'b0);
        tick;
        chk1("c2 busy load", busy, 1'b1);
        tick;
        score_val = 17'd0;
        wait_done("12345 done", n);
        chkn ("12345 latency", n + 3, 20);
        chk1 ("12345 done_src", done_src, 1'b0);
        chk20("12345 score_bcd", score_bcd, 20'h12345);
        chk1 ("12345 ovf_score", ovf_score, 1'b0);
        chk20("12345 best_bcd untouched", best_bcd, 20'h00000);
        tick;
        chk1("after done pulse", done, 1'b0);
        chk1("after done idle", busy, 1'b0);

        // Best boundary: 99999 fits, 100000 saturates.
        pulse(1'b0, 1'b1, 17'd0, 17'd99999);
        wait_done("99999 done", n);
        chk1 ("99999 done_src", done_src, 1'b1);
        chk20("99999 best_bcd", best_bcd, 20'h99999);
        chk1 ("99999 ovf_best", ovf_best, 1'b0);
        chk20("99999 score untouched", score_bcd, 20'h12345);
        tick;
        pulse(1'b0, 1'b1, 17'd0, 17'd100000);
        wait_done("100000 done", n);
        chk20("100000 best_bcd", best_bcd, 20'h99999);
        chk1 ("100000 ovf_best", ovf_best, 1'b1);
        chk1 ("100000 ovf_score", ovf_score, 1'b0);
        tick;

        // Simultaneous requests from reset: score first, best 20 cycles later, twice.
        do_reset;
        pulse(1'b1, 1'b1, 17'd500, 17'd777);
        wait_done("pair1 first", n);
        chkn ("pair1 first latency", n + 1, 20);
        chk1 ("pair1 first src", done_src, 1'b0);
        chk20("pair1 score_bcd", score_bcd, 20'h00500);
        chk20("pair1 best not yet", best_bcd, 20'h00000);
        tick;
        wait_done("pair1 second", n);
        chkn ("pair1 gap", n + 1, 20);
        chk1 ("pair1 second src", done_src, 1'b1);
        chk20("pair1 best_bcd", best_bcd, 20'h00777);
        tick;
        pulse(1'b1, 1'b1, 17'd1, 17'd2);
        wait_done("pair2 first", n);
        chk1 ("pair2 first src", done_src, 1'b0);
        chk20("pair2 score_bcd", score_bcd, 20'h00001);
        tick;
        wait_done("pair2 second", n);
        chk1 ("pair2 second src", done_src, 1'b1);
        chk20("pair2 best_bcd", best_bcd, 20'h00002);
        tick;

        // A lone score grant moves the pointer to best, so the next tie goes to best.
        pulse(1'b1, 1'b0, 17'd3, 17'd0);
        wait_done("solo score", n);
        tick;
        pulse(1'b1, 1'b1, 17'd4, 17'd5);
        wait_done("pair3 first", n);
        chk1 ("pair3 first src", done_src, 1'b1);
        chk20("pair3 best_bcd", best_bcd, 20'h00005);
        tick;
        wait_done("pair3 second", n);
        chk1 ("pair3 second src", done_src, 1'b0);
        chk20("pair3 score_bcd", score_bcd, 20'h00004);
        tick;

        // Re-requests during SHIFT are pended, duplicates collapse into one.
        pulse(1'b1, 1'b0, 17'd7, 17'd0);
        repeat (5) tick;
        pulse(1'b1, 1'b0, 17'd42, 17'd0);
        tick;
        pulse(1'b1, 1'b0, 17'd42, 17'd0);
        wait_done("seven done", n);
        chk20("seven score_bcd", score_bcd, 20'h00007);
        tick;
        wait_done("fortytwo done", n);
        chk20("fortytwo score_bcd", score_bcd, 20'h00042);
        count_done(30, dcnt, cap);
        chkn("no extra conversion", dcnt, 0);

        // Reset during a best SHIFT aborts it; a later request still works.
        pulse(1'b0, 1'b1, 17'd0, 17'd321);
        repeat (8) tick;
        chk1("mid shift busy", busy, 1'b1);
        resetN = 1'b0;
        #1;
        chk1 ("abort busy", busy, 1'b0);
        chk1 ("abort done", done, 1'b0);
        chk1 ("abort done_src", done_src, 1'b0);
        chk20("abort score_bcd", score_bcd, 20'h00000);
        chk20("abort best_bcd", best_bcd, 20'h00000);
        chk1 ("abort ovf_score", ovf_score, 1'b0);
        chk1 ("abort ovf_best", ovf_best, 1'b0);
        tick;
        resetN = 1'b1;
        count_done(25, dcnt, cap);
        chkn ("abort no done", dcnt, 0);
        chk20("abort best stays 0", best_bcd, 20'h00000);
        pulse(1'b1, 1'b0, 17'd5, 17'd0);
        wait_done("post reset done", n);
        chk20("post reset score_bcd", score_bcd, 20'h00005);
        tick;

        // Zero converts to all-zero digits with exactly one done pulse.
        pulse(1'b1, 1'b0, 17'd0, 17'd0);
        count_done(40, dcnt, cap);
        chkn ("zero done count", dcnt, 1);
        chk20("zero score_bcd", cap, 20'h00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_bcd_sequencer.md
SCORE_BCD_SEQUENCER -- requirements
Module: score_bcd_sequencer

Interface
REQ-001 The block SHALL have parameter BIN_W, default 17, giving the binary input width.
REQ-002 The block SHALL have parameter N_DIG, default 5, giving the number of BCD digits.
REQ-003 The block SHALL have parameter MAX_VAL, default 99999, giving the largest displayable value.
REQ-004 Port clk, input, 1 bit: clock; all state SHALL change on its rising edge.
REQ-005 Port resetN, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port req_score, input, 1 bit: one-cycle pulse requesting conversion of score_val.
REQ-007 Port score_val, input, BIN_W bits: current game score, binary.
REQ-008 Port req_best, input, 1 bit: one-cycle pulse requesting conversion of best_val.
REQ-009 Port best_val, input, BIN_W bits: high score, binary.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.
REQ-011 Port done, output, 1 bit: one-cycle pulse when a result bank updates.
REQ-012 Port done_src, output, 1 bit: source of the current result, 0 = score, 1 = best; valid while done is high.
REQ-013 Port score_bcd, output, 4*N_DIG bits: score digits, with the most significant digit in the top nibble.
REQ-014 Port best_bcd, output, 4*N_DIG bits: best digits, same packing as score_bcd.
REQ-015 Port ovf_score and port ovf_best, outputs, 1 bit each: the last converted value of that source exceeded MAX_VAL.

Function
REQ-016 Each request pulse SHALL set a pending flag for its source on the next edge.
REQ-017 The pending flag SHALL clear on the edge that grants that source.
REQ-018 A request arriving in the same cycle as its own grant SHALL leave the pending flag set.
REQ-019 The FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-020 IDLE SHALL transition to LOAD when any pending flag is set; otherwise IDLE SHALL hold.
REQ-021 If both pending flags are set in IDLE, the block SHALL grant the source indicated by a round-robin pointer; the pointer SHALL reset to score and SHALL toggle after each grant to the other source.
REQ-022 LOAD SHALL last 1 cycle.
REQ-023 LOAD SHALL sample the granted source's value and clear the working BCD register.
REQ-024 LOAD SHALL compute the overflow condition as value > MAX_VAL.
REQ-025 SHIFT SHALL last exactly BIN_W cycles, counted by a cycle counter.
REQ-026 Each SHIFT cycle SHALL add 3 to every working digit that is >= 5, then shift {digits, binary} left by 1.
REQ-027 DONE SHALL last 1 cycle, with done=1, and SHALL return to IDLE afterwards.
REQ-028 The granted bank and its ovf flag SHALL hold the new value during the DONE cycle; on overflow, every digit SHALL be 9.
REQ-029 The non-granted bank SHALL never change.
REQ-030 Latency: for a request in cycle 0 with the block idle, done SHALL be high in cycle BIN_W+3.
REQ-031 Input changes after LOAD SHALL not affect an in-flight conversion.
REQ-032 Requests arriving while busy SHALL be pended and served after DONE; they SHALL never be lost.
REQ-033 Duplicate requests from the same source while its flag is pending SHALL collapse into one conversion.
REQ-034 The shift counter SHALL be ceil(log2(BIN_W+1)) bits and SHALL not wrap within a conversion.

Reset
REQ-035 On resetN low, the block SHALL asynchronously set the following: state to IDLE, pending flags to 0, pointer to score, counter to 0, busy=0, done=0, done_src=0, score_bcd=0, best_bcd=0, ovf_score=0, ovf_best=0.
REQ-036 Reset asserted mid-conversion SHALL abort the conversion without writing any bank.
REQ-037 After reset deasserts, the first active edge SHALL see state IDLE.

Structure
REQ-038 A shared package score_pkg SHALL hold the FSM state enum, BIN_W, N_DIG and MAX_VAL.
REQ-039 The per-cycle add-3-and-shift step SHALL be a combinational sub-module bcd_dabble_step (inputs: digits, binary; outputs: next digits, next binary).
REQ-040 The block SHALL instantiate bcd_dabble_step once.

Verification
REQ-041 Bench: req_score with score_val=12345 at cycle 0 -> done=1 and done_src=0 in cycle 20; score_bcd=0x12345, ovf_score=0, best_bcd unchanged.
REQ-042 Bench: req_best with best_val=99999 -> best_bcd=0x99999 and ovf_best=0; then best_val=100000 -> best_bcd=0x99999 and ovf_best=1.
REQ-043 Bench: req_score and req_best in the same cycle from reset -> score completes first (done_src=0), best completes 20 cycles later (done_src=1); repeat both -> same order via alternation.
REQ-044 Bench: req_score with value 7, then req_score again with value 42 mid-SHIFT -> first done gives 0x00007; a second conversion follows and gives 0x00042.
REQ-045 Bench: resetN pulsed low during SHIFT of a best conversion -> all outputs 0 and no done pulse; a new request after reset completes normally.
REQ-046 Bench: score_val=0 -> score_bcd=0x00000 and done pulses exactly once.
